// File: rtl/key_press_gen.sv
// Purpose : push-button stimulus generator; drives an active-low key line with press_cnt press/release cycles.
// Latency : accepted start drives key_out low on the sampling edge; done pulses press_cnt*(PRESS_CYC+RELEASE_CYC) cycles later.
// Backpress: none; start is ignored while busy, abort cancels immediately (done suppressed).
//
// Optional feature: define KEY_BOUNCE_EN to prefix every phase with 2*BOUNCE_N alternating
// bounce segments of BOUNCE_CYC cycles each, starting at the phase's target level.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled in IDLE only
//   press_cnt    number of presses to emit, latched on an accepted start
//   abort        cancels an in-progress sequence (priority over start)
//   key_out      emulated key, active low, idle high
//   busy         high while a sequence is active
//   done         one-cycle pulse on normal completion
//   presses_sent completed press phases in the current/last sequence
module key_press_gen #(
    parameter int PRESS_CYC   = 1_000_000,
    parameter int RELEASE_CYC = 1_000_000,
    parameter int CNT_W       = 24,
    parameter int BOUNCE_N    = 2,
    parameter int BOUNCE_CYC  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] press_cnt,
    input  logic       abort,
    output logic       key_out,
    output logic       busy,
    output logic       done,
    output logic [3:0] presses_sent
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESS   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(PRESS_CYC - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYC - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [3:0]       remaining_q, remaining_d;
    logic [3:0]       presses_q, presses_d;
    logic             key_q, key_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             phase_start;

`ifdef KEY_BOUNCE_EN
    localparam int SEG_TOTAL = 2 * BOUNCE_N;
    // +2 keeps the width >= 1 even when BOUNCE_N is 0.
    localparam int SEG_W     = $clog2(SEG_TOTAL + 2);
    localparam logic [SEG_W-1:0] SEG_END  = SEG_W'(SEG_TOTAL);
    localparam logic [CNT_W-1:0] SEG_LAST = CNT_W'(BOUNCE_CYC - 1);

    // seg_idx_q == SEG_END means bouncing is over and the settled hold is running.
    logic [SEG_W-1:0] seg_idx_q, seg_idx_d;
    logic [CNT_W-1:0] seg_tmr_q, seg_tmr_d;
`endif

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        presses_d   = presses_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        phase_start = 1'b0;
`ifdef KEY_BOUNCE_EN
        seg_idx_d   = seg_idx_q;
        seg_tmr_d   = seg_tmr_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && (press_cnt != 4'd0) && !abort) begin
                    state_d     = ST_PRESS;
                    remaining_d = press_cnt;
                    presses_d   = 4'd0;
                    busy_d      = 1'b1;
                    phase_start = 1'b1;
                end
            end
            ST_PRESS, ST_RELEASE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    timer_d = '0;
                end else begin
`ifdef KEY_BOUNCE_EN
                    if (seg_idx_q != SEG_END) begin
                        if (seg_tmr_q == SEG_LAST) begin
                            seg_tmr_d = '0;
                            seg_idx_d = seg_idx_q + SEG_W'(1);
                        end else begin
                            seg_tmr_d = seg_tmr_q + CNT_W'(1);
                        end
                    end else
`endif
                    begin
                        if (timer_q == ((state_q == ST_PRESS) ? PRESS_LAST : RELEASE_LAST)) begin
                            if (state_q == ST_PRESS) begin
                                // Press counters move only once the settled low hold completes.
                                state_d     = ST_RELEASE;
                                presses_d   = presses_q + 4'd1;
                                remaining_d = remaining_q - 4'd1;
                                phase_start = 1'b1;
                            end else if (remaining_q != 4'd0) begin
                                state_d     = ST_PRESS;
                                phase_start = 1'b1;
                            end else begin
                                state_d = ST_IDLE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                timer_d = '0;
                            end
                        end else begin
                            timer_d = timer_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                timer_d = '0;
            end
        endcase

        if (phase_start) begin
            timer_d   = '0;
`ifdef KEY_BOUNCE_EN
            seg_idx_d = '0;
            seg_tmr_d = '0;
`endif
        end

        // key_out is registered, so its next value follows the next state: low only in PRESS.
        key_d = (state_d != ST_PRESS);
`ifdef KEY_BOUNCE_EN
        // Odd bounce segments sit at the opposite of the phase's target level.
        if ((state_d != ST_IDLE) && (seg_idx_d != SEG_END)) begin
            key_d = key_d ^ seg_idx_d[0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            remaining_q <= 4'd0;
            presses_q   <= 4'd0;
            key_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            presses_q   <= presses_d;
            key_q       <= key_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

`ifdef KEY_BOUNCE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_idx_q <= '0;
            seg_tmr_q <= '0;
        end else begin
            seg_idx_q <= seg_idx_d;
            seg_tmr_q <= seg_tmr_d;
        end
    end
`endif

    assign key_out      = key_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign presses_sent = presses_q;

endmodule

// File: tb/tb_key_press_gen.sv
// Purpose : directed, table-driven bench for key_press_gen (PRESS_CYC=4, RELEASE_CYC=3).
// Latency : one vector per clock; outputs sampled 1 ns after the rising edge.
// Backpress: n/a.
module tb_key_press_gen;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] press_cnt;
    logic       abort;
    logic       key_out;
    logic       busy;
    logic       done;
    logic [3:0] presses_sent;

    int n_vec;
    int n_err;

    key_press_gen #(
        .PRESS_CYC  (4),
        .RELEASE_CYC(3),
        .CNT_W      (8),
        .BOUNCE_N   (1),
        .BOUNCE_CYC (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .press_cnt   (press_cnt),
        .abort       (abort),
        .key_out     (key_out),
        .busy        (busy),
        .done        (done),
        .presses_sent(presses_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [3:0] c;
        logic       a;
        logic       key;
        logic       bsy;
        logic       dn;
        logic [3:0] ps;
    } vec_t;

    vec_t tbl [0:18];

    function automatic logic [6:0] obs();
        return {key_out, busy, done, presses_sent};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: key/busy/done/presses got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply inputs, advance one rising edge, then settle for sampling.
    task automatic step(input logic s, input logic [3:0] c, input logic a);
        start     = s;
        press_cnt = c;
        abort     = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int falls;
        int dones;
        int done_at;
        int n;
        logic prev_key;
        logic bsy_seen;

        n_vec = 0;
        n_err = 0;

        // press_cnt=2: low 4, high 3, low 4, high 3, done with busy fall.
        tbl[0]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[2]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[3]  = '{1'b0, 4'd9, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1};
        tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[10] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[12] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2};
        tbl[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd2};
        tbl[15] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        // start with press_cnt=0 is ignored; abort beats start in IDLE.
        tbl[16] = '{1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[17] = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2};
        tbl[18] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2};

        rst_n     = 1'b0;
        start     = 1'b0;
        press_cnt = 4'd0;
        abort     = 1'b0;
        #12;
        check("reset", obs(), 7'b1_0_0_0000);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_after_reset", obs(), 7'b1_0_0_0000);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].s, tbl[i].c, tbl[i].a);
            check($sformatf("vec%0d", i), obs(),
                  {tbl[i].key, tbl[i].bsy, tbl[i].dn, tbl[i].ps});
        end

        // start re-asserted with press_cnt=5 while a press_cnt=1 sequence runs.
        step(1'b1, 4'd1, 1'b0);
        check("busy_restart_accept", obs(), 7'b0_1_0_0000);
        falls = 0; dones = 0; done_at = -1;
        prev_key = key_out;
        bsy_seen = busy;
        for (int i = 0; i < 12; i++) begin
            step(bsy_seen, 4'd5, 1'b0);
            if (prev_key && !key_out) falls++;
            if (done) begin
                dones++;
                done_at = i;
            end
            prev_key = key_out;
            bsy_seen = busy;
        end
        check_int("busy_restart_falls", falls, 0);
        check_int("busy_restart_dones", dones, 1);
        check_int("busy_restart_done_cycle", done_at, 6);
        check("busy_restart_end", obs(), 7'b1_0_0_0001);

        // press_cnt=3, abort during the second press.
        step(1'b1, 4'd3, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 4'd0, 1'b0);
        check("abort_pre", obs(), 7'b0_1_0_0001);
        step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b1);
        check("abort_now", obs(), 7'b1_0_0_0001);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 4'd0, 1'b0);
            if (done) dones++;
        end
        check_int("abort_no_done", dones, 0);
        check("abort_hold", obs(), 7'b1_0_0_0001);

        // Asynchronous reset in the middle of the second press.
        step(1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 4'd0, 1'b0);
        check("rst_pre", obs(), 7'b0_1_0_0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", obs(), 7'b1_0_0_0000);
        #2;
        rst_n = 1'b1;
        step(1'b1, 4'd1, 1'b0);
        check("rst_after_accept", obs(), 7'b0_1_0_0000);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        check("rst_after_release", obs(), 7'b1_1_0_0001);
        for (int i = 0; i < 2; i++) step(1'b0, 4'd0, 1'b0);
        step(1'b0, 4'd0, 1'b0);
        check("rst_after_done", obs(), 7'b1_0_1_0001);

        // press_cnt=15: full length and no wrap of presses_sent.
        step(1'b1, 4'd15, 1'b0);
        n = 0;
        while (n < 200) begin
            step(1'b0, 4'd0, 1'b0);
            n++;
            if (done) break;
        end
        check_int("max_len", n, 105);
        check("max_end", obs(), 7'b1_0_1_1111);
        step(1'b0, 4'd0, 1'b0);
        check("max_idle", obs(), 7'b1_0_0_1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
